// File: rtl/cpu_register_file_mp.sv
// Multi-read-port integer register file with a clear sequencer that zeroes every register after reset or on clr_req.
// Optional same-cycle write-to-read bypass when CPU_REGFILE_BYPASS_EN is defined.
module cpu_register_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0] ra,
  output logic [NRD*XLEN-1:0]        rd,
  input  logic [$clog2(NREGS)-1:0]   wa,
  input  logic [XLEN-1:0]            wd,
  input  logic                       we,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       wr_drop
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_wr_drop;
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic w_wr_req;
  logic w_wr_ok;

  assign busy     = (r_state == S_SWEEP);
  assign wr_drop  = r_wr_drop;
  assign w_wr_req = we && (wa != '0);
  // clear has priority over a write arriving in the same cycle
  assign w_wr_ok  = w_wr_req && !busy && !clr_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_SWEEP;
      r_cnt     <= AW'(1);
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_req && (busy || clr_req);
      case (r_state)
        S_SWEEP: begin
          if (r_cnt == {AW{1'b1}}) r_state <= S_IDLE;
          else                     r_cnt   <= r_cnt + AW'(1);
        end
        S_IDLE: begin
          if (clr_req) begin
            r_state <= S_SWEEP;
            r_cnt   <= AW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately untouched by reset; the sweep does the zeroing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy)         r_regs[r_cnt] <= '0;
      else if (w_wr_ok) r_regs[wa]    <= wd;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_byp;
    assign w_ra = ra[i*AW +: AW];
`ifdef CPU_REGFILE_BYPASS_EN
    assign w_byp = w_wr_ok && (wa == w_ra);
`else
    assign w_byp = 1'b0;
`endif
    assign rd[i*XLEN +: XLEN] = (busy || (w_ra == '0)) ? '0 :
                                w_byp                  ? wd : r_regs[w_ra];
  end
endmodule
